ifu_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction ROM. Owns the PC and drives the ROM word address. Captures the ROM's combinational read data into a 2-entry fetch buffer. Presents {pc, inst} to decode over a valid/ready handshake and supports redirect (branch/jump) with flush.

---
 rtl/ifu_pkg.sv | 12 +
 rtl/fetch_buf.sv | 42 ++++
 rtl/ifu_fetch.sv | 77 +++++++
 tb/tb_ifu_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;
  localparam int INST_BYTES = 4;
  localparam int DEF_PCW = 32;
  localparam int DEF_DW = 32;
  localparam logic [DEF_PCW-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_PCW-1:0] pc;
    logic [DEF_DW-1:0]  inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO between fetch and decode; head is read combinationally.
module fetch_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (enq && wr_ptr_reg == 1'(gi)) begin
        mem[gi] <= enq_data;
      end
    end
  end

  // Flush only drops pointers/count; stale slot contents are never exposed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg ^ enq;
      rd_ptr_reg <= rd_ptr_reg ^ deq;
      count_reg  <= count_reg + {1'b0, enq} - {1'b0, deq};
    end
  end

  assign head_data = (count_reg != 2'd0) ? mem[rd_ptr_reg] : '0;
  assign count     = count_reg;
endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, addresses the ROM and buffers {pc, inst} for decode.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int             AW       = 10,
  parameter int             DW       = 32,
  parameter int             PCW      = 32,
  parameter logic [PCW-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  output logic [AW-1:0]  rom_raddr,
  input  logic [DW-1:0]  rom_rdata,
  input  logic           redirect_valid,
  input  logic [PCW-1:0] redirect_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PCW-1:0] out_pc,
  output logic [DW-1:0]  out_inst
);
  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [DW-1:0]  inst;
  } entry_t;

  logic [PCW-1:0] pc_reg;
  logic [PCW-1:0] pc_next;
  logic [1:0]     count;
  logic           deq;
  logic           enq;
  entry_t         enq_entry;
  entry_t         head_entry;

  assign rom_raddr = pc_reg[AW+1:2];
  assign out_valid = (count != 2'd0);
  assign deq       = out_valid & out_ready;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign enq       = !rst && !redirect_valid && ((count < 2'd2) || deq);

  always_comb begin
    enq_entry.pc   = pc_reg;
    enq_entry.inst = rom_rdata;
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc & ~PCW'(3);
    end else if (enq) begin
      pc_next = pc_reg + PCW'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  fetch_buf #(
    .WIDTH($bits(entry_t))
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .enq       (enq),
    .enq_data  (enq_entry),
    .deq       (deq),
    .head_data (head_entry),
    .count     (count)
  );

  assign out_pc   = head_entry.pc;
  assign out_inst = head_entry.inst;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed plus randomized bench for ifu_fetch against a queue-based model.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_raddr;
  logic [31:0] rom_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  logic [31:0] rom [1024];
  int tests = 0;
  int fails = 0;

  fetch_entry_t mq[$];
  fetch_entry_t ment;
  logic [31:0]  mpc;
  bit           model_ok = 0;
  bit           m_deq;
  bit           m_enq;

  always #5 clk = ~clk;

  assign rom_rdata = rom[rom_raddr];

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_raddr      (rom_raddr),
    .rom_rdata      (rom_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of at most two {pc,inst} entries and a byte PC.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mpc = DEF_RESET_PC;
      model_ok = 1;
    end else if (model_ok) begin
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        m_deq = (mq.size() != 0) && out_ready;
        m_enq = (mq.size() < 2) || m_deq;
        if (m_deq) void'(mq.pop_front());
        if (m_enq) begin
          ment.pc   = mpc;
          ment.inst = rom[mpc[11:2]];
          mq.push_back(ment);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_raddr", {22'd0, rom_raddr}, {22'd0, mpc[11:2]});
      check("model_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        check("model_pc", out_pc, mq[0].pc);
        check("model_inst", out_inst, mq[0].inst);
      end else begin
        check("model_pc_idle", out_pc, 32'd0);
        check("model_inst_idle", out_inst, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + i;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(2);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_raddr", {22'd0, rom_raddr}, 32'd0);

    // Backpressure fills the buffer and stalls the PC.
    rst = 1'b0;
    step(5);
    check("bp_raddr", {22'd0, rom_raddr}, 32'd2);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_head_inst", out_inst, 32'hA000_0000);

    // One-cycle deq while full: 0x0 leaves, 0x8 enters.
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("fd_head_pc", out_pc, 32'h4);
    check("fd_head_inst", out_inst, 32'hA000_0001);
    check("fd_raddr", {22'd0, rom_raddr}, 32'd3);
    step(1);
    check("fd_stall_pc", out_pc, 32'h4);

    // Redirect while full and dequeuing: flush wins.
    redirect_valid = 1'b1; redirect_pc = 32'h103; out_ready = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    check("rd_flush_valid", {31'd0, out_valid}, 32'd0);
    check("rd_raddr", {22'd0, rom_raddr}, 32'h40);
    step(1);
    check("rd_first_pc", out_pc, 32'h100);
    check("rd_first_inst", out_inst, 32'hA000_0040);
    step(1);
    check("rd_second_pc", out_pc, 32'h104);

    // ROM aliasing past the top of the image.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFC;
    step(1);
    redirect_valid = 1'b0;
    check("al_raddr_top", {22'd0, rom_raddr}, 32'd1023);
    step(1);
    check("al_top_pc", out_pc, 32'hFFC);
    check("al_top_inst", out_inst, 32'hA000_03FF);
    check("al_wrap_raddr", {22'd0, rom_raddr}, 32'd0);
    step(1);
    check("al_wrap_pc", out_pc, 32'h1000);
    check("al_wrap_inst", out_inst, 32'hA000_0000);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    check("pcw_top_pc", out_pc, 32'hFFFF_FFFC);
    step(1);
    check("pcw_wrap_pc", out_pc, 32'h0);

    // Reset with a full buffer and a competing redirect.
    out_ready = 1'b0;
    step(3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(1);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_pc", out_pc, 32'd0);
    check("mr_raddr", {22'd0, rom_raddr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("seq_valid", {31'd0, out_valid}, 32'd1);
      check("seq_pc", out_pc, 32'(4 * i));
      check("seq_inst", out_inst, 32'hA000_0000 + 32'(i));
    end

    // Randomized traffic, checked each cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0; redirect_valid = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
